// File: rtl/p_hit_feeder.sv
// p_hit_feeder: pops one ray/triangle record from an upstream FWFT FIFO and
// issues it exactly once to each of p_hit's four input FIFO ports.
module p_hit_feeder #(
    parameter int D_BITS   = 32,
    parameter int Q_BITS   = 16,
    parameter int CNT_BITS = 16
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic signed [3*D_BITS-1:0]     in_tri_normal,
    input  logic signed [3*D_BITS-1:0]     in_v0,
    input  logic signed [3*D_BITS-1:0]     in_origin,
    input  logic signed [3*D_BITS-1:0]     in_dir,
    input  logic                           in_empty,
    output logic                           in_rd_en,
    output logic signed [3*D_BITS-1:0]     tri_normal_1,
    output logic signed [3*D_BITS-1:0]     tri_normal_2,
    output logic signed [3*D_BITS-1:0]     v0,
    output logic signed [3*D_BITS-1:0]     origin_1,
    output logic signed [3*D_BITS-1:0]     origin_2,
    output logic signed [3*D_BITS-1:0]     dir_1,
    output logic signed [3*D_BITS-1:0]     dir_2,
    output logic [3:0]                     out_wr_en,
    input  logic [3:0]                     out_full,
    output logic                           busy,
    output logic [CNT_BITS-1:0]            issued_cnt
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SEND = 1'b1;

    // Fixed-point words are carried through untouched; the fraction width only
    // has to be representable inside the word.
    if (Q_BITS > D_BITS) begin : g_q_bits_exceed_word
    end

    logic                       valid_reg;
    logic                       valid_next;
    logic [3:0]                 pending_reg;
    logic [3:0]                 pending_next;
    logic [CNT_BITS-1:0]        cnt_reg;
    logic [CNT_BITS-1:0]        cnt_next;
    logic signed [3*D_BITS-1:0] normal_reg;
    logic signed [3*D_BITS-1:0] v0_reg;
    logic signed [3*D_BITS-1:0] origin_reg;
    logic signed [3*D_BITS-1:0] dir_reg;

    logic [0:0] state;
    logic [3:0] wr_en;
    logic       done;
    logic       pop;

    assign state = valid_reg ? SEND : IDLE;

    // Each port writes independently as soon as it is pending and has room.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_port
            assign wr_en[gi] = !reset && (state == SEND) && pending_reg[gi] && !out_full[gi];
        end
    endgenerate

    assign done = valid_reg && ((pending_reg & ~wr_en) == 4'b0000);
    assign pop  = !reset && !in_empty && (!valid_reg || done);

    always_comb begin
        valid_next   = valid_reg;
        pending_next = pending_reg & ~wr_en;
        cnt_next     = cnt_reg;
        if (done) begin
            cnt_next = cnt_reg + 1'b1;
        end
        // A pop on the completing cycle overwrites the finished record directly.
        if (pop) begin
            valid_next   = 1'b1;
            pending_next = 4'b1111;
        end else if (done) begin
            valid_next   = 1'b0;
            pending_next = 4'b0000;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            valid_reg   <= 1'b0;
            pending_reg <= 4'b0000;
            cnt_reg     <= '0;
            normal_reg  <= '0;
            v0_reg      <= '0;
            origin_reg  <= '0;
            dir_reg     <= '0;
        end else begin
            valid_reg   <= valid_next;
            pending_reg <= pending_next;
            cnt_reg     <= cnt_next;
            if (pop) begin
                normal_reg <= in_tri_normal;
                v0_reg     <= in_v0;
                origin_reg <= in_origin;
                dir_reg    <= in_dir;
            end
        end
    end

    assign in_rd_en     = pop;
    assign out_wr_en    = wr_en;
    assign busy         = valid_reg;
    assign issued_cnt   = cnt_reg;
    assign tri_normal_1 = normal_reg;
    assign tri_normal_2 = normal_reg;
    assign v0           = v0_reg;
    assign origin_1     = origin_reg;
    assign origin_2     = origin_reg;
    assign dir_1        = dir_reg;
    assign dir_2        = dir_reg;

endmodule

// File: tb/tb_p_hit_feeder.sv
// Directed bench for p_hit_feeder: a queue models the upstream FWFT FIFO and
// each scenario task checks strobes, data copies and the issued counter.
module tb_p_hit_feeder;
    localparam int D = 32;
    typedef logic signed [3*D-1:0] vec_t;
    typedef struct {
        vec_t n;
        vec_t v;
        vec_t o;
        vec_t d;
    } rec_t;

    logic       clock;
    logic       reset;
    vec_t       in_tri_normal, in_v0, in_origin, in_dir;
    logic       in_empty;
    logic       in_rd_en;
    vec_t       tri_normal_1, tri_normal_2, v0, origin_1, origin_2, dir_1, dir_2;
    logic [3:0] out_wr_en;
    logic [3:0] out_full;
    logic       busy;
    logic [15:0] issued_cnt;

    logic       u4_rd_en;
    vec_t       u4_tn1, u4_tn2, u4_v0, u4_o1, u4_o2, u4_d1, u4_d2;
    logic [3:0] u4_wr_en;
    logic       u4_busy;
    logic [3:0] issued_cnt4;

    p_hit_feeder #(.D_BITS(32), .Q_BITS(16), .CNT_BITS(16)) u_dut (
        .clock(clock), .reset(reset),
        .in_tri_normal(in_tri_normal), .in_v0(in_v0), .in_origin(in_origin), .in_dir(in_dir),
        .in_empty(in_empty), .in_rd_en(in_rd_en),
        .tri_normal_1(tri_normal_1), .tri_normal_2(tri_normal_2), .v0(v0),
        .origin_1(origin_1), .origin_2(origin_2), .dir_1(dir_1), .dir_2(dir_2),
        .out_wr_en(out_wr_en), .out_full(out_full), .busy(busy), .issued_cnt(issued_cnt)
    );

    p_hit_feeder #(.D_BITS(32), .Q_BITS(16), .CNT_BITS(4)) u_dut4 (
        .clock(clock), .reset(reset),
        .in_tri_normal(in_tri_normal), .in_v0(in_v0), .in_origin(in_origin), .in_dir(in_dir),
        .in_empty(in_empty), .in_rd_en(u4_rd_en),
        .tri_normal_1(u4_tn1), .tri_normal_2(u4_tn2), .v0(u4_v0),
        .origin_1(u4_o1), .origin_2(u4_o2), .dir_1(u4_d1), .dir_2(u4_d2),
        .out_wr_en(u4_wr_en), .out_full(out_full), .busy(u4_busy), .issued_cnt(issued_cnt4)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   exp_cnt = 0;
    rec_t fifo_q[$];

    logic        s_rd, s_busy;
    logic [3:0]  s_wr, s_cnt4;
    logic [15:0] s_cnt;
    vec_t        s_tn1, s_tn2, s_v0, s_o1, s_o2, s_d1, s_d2;

    function automatic vec_t vec(int x, int y, int z);
        logic [31:0] xs, ys, zs;
        xs = 32'(x * 65536);
        ys = 32'(y * 65536);
        zs = 32'(z * 65536);
        return {xs, ys, zs};
    endfunction

    function automatic rec_t mk(int b);
        rec_t r;
        r.n = vec(b, b + 1, b + 2);
        r.v = vec(b + 3, b + 4, b + 5);
        r.o = vec(b + 6, b + 7, b + 8);
        r.d = vec(-b, b + 9, -1);
        return r;
    endfunction

    // One clock: present the FIFO head, sample at negedge, pop on the edge.
    task automatic cycle();
        if (fifo_q.size() > 0) begin
            in_tri_normal = fifo_q[0].n;
            in_v0         = fifo_q[0].v;
            in_origin     = fifo_q[0].o;
            in_dir        = fifo_q[0].d;
            in_empty      = 1'b0;
        end else begin
            in_empty = 1'b1;
        end
        @(negedge clock);
        s_rd = in_rd_en;   s_wr = out_wr_en;  s_busy = busy;
        s_cnt = issued_cnt; s_cnt4 = issued_cnt4;
        s_tn1 = tri_normal_1; s_tn2 = tri_normal_2; s_v0 = v0;
        s_o1 = origin_1; s_o2 = origin_2; s_d1 = dir_1; s_d2 = dir_2;
        @(posedge clock);
        if (s_rd && fifo_q.size() > 0) void'(fifo_q.pop_front());
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_empty = 1'b0; out_full = 4'b0000;
        in_tri_normal = vec(1, 1, 1); in_v0 = '0; in_origin = '0; in_dir = '0;
        @(posedge clock); #1;
        @(negedge clock);
        n_cmp++;
        if (in_rd_en !== 1'b0 || out_wr_en !== 4'b0000) begin
            n_bad++;
            $display("FAIL reset_strobes: rd=%b wr=%b required rd=0 wr=0000", in_rd_en, out_wr_en);
        end
        n_cmp++;
        if (busy !== 1'b0 || issued_cnt !== 16'd0) begin
            n_bad++;
            $display("FAIL reset_state: busy=%b cnt=%0d required 0/0", busy, issued_cnt);
        end
        n_cmp++;
        if (tri_normal_1 !== '0 || dir_2 !== '0 || v0 !== '0 || origin_2 !== '0) begin
            n_bad++;
            $display("FAIL reset_data: tn1=%h dir2=%h required 0", tri_normal_1, dir_2);
        end
        @(posedge clock); #1;
        reset = 1'b0; in_empty = 1'b1; exp_cnt = 0;
        $display("reset: checked");
    endtask

    task automatic test_single();
        rec_t a;
        a.n = vec(1, 2, 3); a.v = vec(4, 5, 6); a.o = vec(7, 8, 9); a.d = vec(0, 0, -1);
        fifo_q.push_back(a); out_full = 4'b0000;
        cycle();
        n_cmp++;
        if (s_rd !== 1'b1 || s_wr !== 4'b0000) begin
            n_bad++;
            $display("FAIL single_pop: rd=%b wr=%b required rd=1 wr=0000", s_rd, s_wr);
        end
        cycle();
        n_cmp++;
        if (s_rd !== 1'b0 || s_wr !== 4'b1111) begin
            n_bad++;
            $display("FAIL single_write: rd=%b wr=%b required rd=0 wr=1111", s_rd, s_wr);
        end
        n_cmp++;
        if (s_tn1 !== a.n || s_tn2 !== a.n || s_v0 !== a.v) begin
            n_bad++;
            $display("FAIL single_normal: tn1=%h tn2=%h v0=%h required %h %h", s_tn1, s_tn2, s_v0, a.n, a.v);
        end
        n_cmp++;
        if (s_o1 !== a.o || s_o2 !== a.o || s_d1 !== a.d || s_d2 !== a.d) begin
            n_bad++;
            $display("FAIL single_ray: o1=%h o2=%h d1=%h d2=%h required %h %h", s_o1, s_o2, s_d1, s_d2, a.o, a.d);
        end
        exp_cnt += 1;
        cycle();
        n_cmp++;
        if (s_busy !== 1'b0 || s_cnt !== 16'(exp_cnt)) begin
            n_bad++;
            $display("FAIL single_done: busy=%b cnt=%0d required busy=0 cnt=%0d", s_busy, s_cnt, exp_cnt);
        end
        $display("single: record issued, cnt=%0d", s_cnt);
    endtask

    task automatic test_back_to_back();
        rec_t r[4];
        for (int k = 0; k < 4; k++) begin
            r[k] = mk(10 * (k + 1));
            fifo_q.push_back(r[k]);
        end
        out_full = 4'b0000;
        for (int c = 0; c < 6; c++) begin
            logic       exp_rd;
            logic [3:0] exp_wr;
            exp_rd = (c < 4);
            exp_wr = (c >= 1 && c <= 4) ? 4'b1111 : 4'b0000;
            cycle();
            n_cmp++;
            if (s_rd !== exp_rd || s_wr !== exp_wr) begin
                n_bad++;
                $display("FAIL b2b_strobe c%0d: rd=%b wr=%b required rd=%b wr=%b", c, s_rd, s_wr, exp_rd, exp_wr);
            end
            if (c >= 1 && c <= 4) begin
                n_cmp++;
                if (s_tn1 !== r[c-1].n || s_v0 !== r[c-1].v || s_o2 !== r[c-1].o || s_d1 !== r[c-1].d) begin
                    n_bad++;
                    $display("FAIL b2b_data c%0d: tn1=%h d1=%h required %h %h", c, s_tn1, s_d1, r[c-1].n, r[c-1].d);
                end
            end
        end
        exp_cnt += 4;
        n_cmp++;
        if (s_cnt !== 16'(exp_cnt) || s_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_cnt: cnt=%0d busy=%b required cnt=%0d busy=0", s_cnt, s_busy, exp_cnt);
        end
        $display("back_to_back: 4 records, cnt=%0d", s_cnt);
    endtask

    task automatic test_port2_full();
        rec_t a, b;
        logic [3:0] full_t[8] = '{4'b0000, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0000};
        logic [3:0] wr_t[8]   = '{4'b0000, 4'b1011, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b1111};
        logic       rd_t[8]   = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        a = mk(100); b = mk(200);
        fifo_q.push_back(a); fifo_q.push_back(b);
        for (int c = 0; c < 8; c++) begin
            out_full = full_t[c];
            cycle();
            n_cmp++;
            if (s_rd !== rd_t[c] || s_wr !== wr_t[c]) begin
                n_bad++;
                $display("FAIL port2_full c%0d: rd=%b wr=%b required rd=%b wr=%b", c, s_rd, s_wr, rd_t[c], wr_t[c]);
            end
            if (c >= 1 && c <= 5) begin
                n_cmp++;
                if (s_busy !== 1'b1 || s_d2 !== a.d) begin
                    n_bad++;
                    $display("FAIL port2_hold c%0d: busy=%b d2=%h required busy=1 d2=%h", c, s_busy, s_d2, a.d);
                end
            end
        end
        n_cmp++;
        if (s_tn2 !== b.n || s_o1 !== b.o) begin
            n_bad++;
            $display("FAIL port2_next: tn2=%h o1=%h required %h %h", s_tn2, s_o1, b.n, b.o);
        end
        exp_cnt += 2;
        out_full = 4'b0000;
        cycle();
        n_cmp++;
        if (s_cnt !== 16'(exp_cnt)) begin
            n_bad++;
            $display("FAIL port2_cnt: cnt=%0d required %0d", s_cnt, exp_cnt);
        end
        $display("port2_full: cnt=%0d", s_cnt);
    endtask

    task automatic test_staggered();
        logic [3:0] full_t[7] = '{4'b0000, 4'b1001, 4'b1001, 4'b1000, 4'b1000, 4'b0000, 4'b0000};
        logic [3:0] wr_t[7]   = '{4'b0000, 4'b0110, 4'b0000, 4'b0001, 4'b0000, 4'b1000, 4'b1111};
        logic       rd_t[7]   = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        fifo_q.push_back(mk(300)); fifo_q.push_back(mk(400));
        for (int c = 0; c < 7; c++) begin
            out_full = full_t[c];
            cycle();
            n_cmp++;
            if (s_rd !== rd_t[c] || s_wr !== wr_t[c]) begin
                n_bad++;
                $display("FAIL stagger c%0d: rd=%b wr=%b required rd=%b wr=%b", c, s_rd, s_wr, rd_t[c], wr_t[c]);
            end
        end
        exp_cnt += 2;
        out_full = 4'b0000;
        cycle();
        n_cmp++;
        if (s_cnt !== 16'(exp_cnt) || s_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL stagger_cnt: cnt=%0d busy=%b required %0d/0", s_cnt, s_busy, exp_cnt);
        end
        $display("staggered: cnt=%0d", s_cnt);
    endtask

    task automatic test_reset_mid();
        rec_t b;
        b = mk(500);
        fifo_q.push_back(mk(450));
        out_full = 4'b0000; cycle();
        out_full = 4'b0100; cycle();
        n_cmp++;
        if (s_wr !== 4'b1011) begin
            n_bad++;
            $display("FAIL rstmid_partial: wr=%b required 1011", s_wr);
        end
        fifo_q.push_back(b);
        reset = 1'b1; out_full = 4'b0000;
        cycle();
        n_cmp++;
        if (s_wr !== 4'b0000 || s_rd !== 1'b0) begin
            n_bad++;
            $display("FAIL rstmid_strobes: wr=%b rd=%b required 0000/0", s_wr, s_rd);
        end
        reset = 1'b0; exp_cnt = 0;
        cycle();
        n_cmp++;
        if (s_busy !== 1'b0 || s_cnt !== 16'd0 || s_tn1 !== '0 || s_d2 !== '0 || s_wr !== 4'b0000) begin
            n_bad++;
            $display("FAIL rstmid_cleared: busy=%b cnt=%0d tn1=%h wr=%b required 0", s_busy, s_cnt, s_tn1, s_wr);
        end
        n_cmp++;
        if (s_rd !== 1'b1) begin
            n_bad++;
            $display("FAIL rstmid_pop: rd=%b required 1", s_rd);
        end
        cycle();
        n_cmp++;
        if (s_wr !== 4'b1111 || s_d2 !== b.d || s_v0 !== b.v) begin
            n_bad++;
            $display("FAIL rstmid_next: wr=%b d2=%h required 1111 %h", s_wr, s_d2, b.d);
        end
        exp_cnt += 1;
        cycle();
        n_cmp++;
        if (s_cnt !== 16'(exp_cnt)) begin
            n_bad++;
            $display("FAIL rstmid_cnt: cnt=%0d required %0d", s_cnt, exp_cnt);
        end
        $display("reset_mid: cnt=%0d", s_cnt);
    endtask

    task automatic test_wrap();
        reset = 1'b1; out_full = 4'b0000;
        cycle();
        reset = 1'b0; exp_cnt = 0;
        for (int k = 0; k < 17; k++) fifo_q.push_back(mk(k + 1));
        for (int c = 0; c < 19; c++) begin
            cycle();
            if (c == 9) begin
                n_cmp++;
                if (s_wr !== 4'b1111 || s_tn1 !== mk(9).n) begin
                    n_bad++;
                    $display("FAIL wrap_stream: wr=%b tn1=%h required 1111 %h", s_wr, s_tn1, mk(9).n);
                end
            end
        end
        exp_cnt = 17;
        n_cmp++;
        if (s_cnt !== 16'(exp_cnt)) begin
            n_bad++;
            $display("FAIL wrap_cnt16: cnt=%0d required %0d", s_cnt, exp_cnt);
        end
        n_cmp++;
        if (s_cnt4 !== 4'd1) begin
            n_bad++;
            $display("FAIL wrap_cnt4: cnt=%0d required 1", s_cnt4);
        end
        $display("wrap: cnt16=%0d cnt4=%0d", s_cnt, s_cnt4);
    endtask

    initial begin
        reset = 1'b1; in_empty = 1'b1; out_full = 4'b0000;
        in_tri_normal = '0; in_v0 = '0; in_origin = '0; in_dir = '0;
        test_reset();
        test_single();
        test_back_to_back();
        test_port2_full();
        test_staggered();
        test_reset_mid();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/p_hit_feeder.md
Name: p_hit_feeder

Overview:
- Transmitter side of the p_hit input interface.
- Pops one ray/triangle record from an upstream first-word-fall-through (FWFT) FIFO and fans it out to the four independent input FIFO ports of p_hit: tri_normal/v0, tri_normal/origin/dir, dir copy, origin copy.
- Each port is written exactly once per record, each with its own full back-pressure, so a stall on one port never duplicates or drops writes on another.
- Sits between the ray/triangle scheduler FIFO and p_hit.

Parameters:
- D_BITS, 32, width of each fixed-point vector component.
- Q_BITS, 16, fractional bits; carried for consistency only, no arithmetic is performed.
- CNT_BITS, 16, width of the issued-record counter.

Ports:
- clock  input  1  system clock
- reset  input  1  synchronous, active-high reset
- in_tri_normal  input  3 x D_BITS signed  triangle normal [x,y,z] from upstream FIFO head
- in_v0  input  3 x D_BITS signed  triangle vertex 0
- in_origin  input  3 x D_BITS signed  ray origin
- in_dir  input  3 x D_BITS signed  ray direction
- in_empty  input  1  upstream FIFO empty
- in_rd_en  output  1  pop upstream FIFO
- tri_normal_1, tri_normal_2  output  3 x D_BITS signed each  normal copies
- v0  output  3 x D_BITS signed  vertex 0
- origin_1, origin_2  output  3 x D_BITS signed each  origin copies
- dir_1, dir_2  output  3 x D_BITS signed each  direction copies
- out_wr_en  output  [3:0] x 1  per-port write strobes to p_hit in_wr_en
- out_full  input  [3:0] x 1  per-port full from p_hit in_full
- busy  output  1  a record is held and not fully issued
- issued_cnt  output  CNT_BITS  count of fully issued records

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Port grouping (fixed):
  - Port 0 carries tri_normal_1 and v0.
  - Port 1 carries tri_normal_2, origin_1 and dir_1.
  - Port 2 carries dir_2.
  - Port 3 carries origin_2.
- Copy rule: tri_normal_1 = tri_normal_2, origin_1 = origin_2 and dir_1 = dir_2, all taken from the held record.
- State:
  - valid: a record is held.
  - pending[3:0]: ports not yet written for the held record.
  - hold registers for normal, v0, origin and dir.
- FSM has two states, derived from valid:
  - IDLE (valid=0): out_wr_en all 0.
  - SEND (valid=1): for each port i, out_wr_en[i] = pending[i] && !out_full[i], combinational in the same cycle. No port is ever written twice per record.
- Completion: done = valid && ((pending & ~out_wr_en) == 0).
- Pop rule: in_rd_en = !in_empty && (!valid || done), combinational.
- On in_rd_en:
  - Load hold registers from the FIFO head.
  - Set pending to 4'b1111 and valid to 1.
  - If the previous record is done in the same cycle, the new load replaces it, giving back-to-back records with no bubble.
- On done with in_empty=1: valid goes to 0, pending to 0, FSM returns to IDLE.
- Otherwise: pending <= pending & ~out_wr_en.
- Data stability: output data are driven only from hold registers and stay stable from load until done.
- Latency: a pop in cycle N gives the earliest writes in cycle N+1. Throughput is one record per cycle when no port is full.
- Counter: issued_cnt increments by 1 in each cycle where done=1. It wraps modulo 2^CNT_BITS.
- busy = valid.
- Reset:
  - valid=0, pending=0, all hold registers and data outputs 0, issued_cnt=0.
  - in_rd_en and out_wr_en are forced to 0 in any cycle where reset is high.
  - Reset mid-record discards the held record; remaining pending ports are not written.
- Boundary cases:
  - All four ports full: no writes, no pop, state unchanged, indefinitely.
  - A port deasserts full in the same cycle it is pending: it is written that cycle.
  - in_empty toggling while valid and not done: in_rd_en stays 0.

Test Plan:
- Single record, normal=(1,2,3)<<16, v0=(4,5,6)<<16, origin=(7,8,9)<<16, dir=(0,0,-1)<<16, all out_full=0:
  - in_rd_en pulses one cycle.
  - The next cycle all four out_wr_en=1 with correct copies on every output.
  - issued_cnt=1, busy returns to 0.
- Four back-to-back records with no full:
  - in_rd_en high 4 consecutive cycles.
  - out_wr_en=4'b1111 for 4 consecutive cycles, one cycle later.
  - Data ordered exactly, issued_cnt=4.
- out_full[2]=1 for 5 cycles after load:
  - Ports 0, 1 and 3 are written once in the first cycle.
  - Port 2 is written once in the cycle full drops.
  - No pop before that cycle, and no repeat writes.
- Staggered full (port0 full cycles 1-2, port3 full cycles 1-4):
  - Each port is written exactly once.
  - Next pop occurs in the same cycle port3 is written.
- Reset asserted while pending=4'b0100:
  - Outputs zero, issued_cnt=0, busy=0.
  - Port 2 is never written.
  - The next record after reset issues normally.
- CNT_BITS=4 with 17 records: issued_cnt reads 1 (wrap).
